stream_unpacker: RTL and testbench

STREAM_UNPACKER -- requirements
Module: stream_unpacker

---
 rtl/stream_unpacker_pkg.sv | 37 +++
 rtl/stream_unpacker_word_mux.sv | 33 +++
 rtl/stream_unpacker.sv | 114 +++++++++++
 tb/tb_stream_unpacker.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_unpacker_pkg.sv
// Shared definitions for the stream unpacker: control state encoding and
// the width helpers used to size the count and word-index fields.
package stream_unpacker_pkg;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Number of halvings (rounding up) needed to reach 1, i.e. ceil(log2(value)).
    function automatic int clog2_int(input int value);
        int v;
        int n;
        v = value;
        n = 0;
        while (v > 1) begin
            v = ceil_div(v, 2);
            n = n + 1;
        end
        return n;
    endfunction

    function automatic int cnt_width(input int ratio);
        int w;
        w = clog2_int(ratio + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int idx_width(input int ratio);
        int w;
        w = clog2_int(ratio);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stream_unpacker_word_mux.sv
// RATIO-way word select out of a packed beat; MSB_FIRST reverses the order
// so that index 0 picks the top word instead of the bottom one.
module unpacker_word_mux
    import stream_unpacker_pkg::*;
#(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 64,
    parameter int MSB_FIRST = 0,
    localparam int RATIO    = IN_WIDTH / OUT_WIDTH,
    localparam int IDX_W    = idx_width(IN_WIDTH / OUT_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic [IDX_W-1:0]     i_idx,
    output logic [OUT_WIDTH-1:0] o_word
);

    logic [OUT_WIDTH-1:0] w_words [RATIO];

    for (genvar g = 0; g < RATIO; g++) begin : g_word
        localparam int SRC = (MSB_FIRST != 0) ? (RATIO - 1 - g) : g;
        assign w_words[g] = i_data[SRC*OUT_WIDTH +: OUT_WIDTH];
    end

    always_comb begin
        o_word = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (i_idx == IDX_W'(k)) begin
                o_word = w_words[k];
            end
        end
    end

endmodule

// File: rtl/stream_unpacker.sv
// Splits each packed input beat into up to RATIO output words, one per
// output handshake, with zero-bubble hand-over between consecutive beats.
module stream_unpacker
    import stream_unpacker_pkg::*;
#(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 64,
    parameter int MSB_FIRST = 0,
    localparam int CNT_W    = cnt_width(IN_WIDTH / OUT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [CNT_W-1:0]     in_count,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = idx_width(RATIO);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || OUT_WIDTH > IN_WIDTH) begin : g_bad_widths
        $error("stream_unpacker: IN_WIDTH must be a whole multiple of OUT_WIDTH");
    end

    logic [0:0]           r_state;
    logic [IN_WIDTH-1:0]  r_hold;
    logic                 r_hold_last;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_rem;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic [OUT_WIDTH-1:0] r_out_data;

    logic [CNT_W-1:0]     w_count;
    logic                 w_in_hs;
    logic                 w_out_hs;
    logic                 w_rem_one;
    logic                 w_final;
    logic                 w_advance;
    logic [IN_WIDTH-1:0]  w_mux_src;
    logic [IDX_W-1:0]     w_mux_idx;
    logic [OUT_WIDTH-1:0] w_word;

    assign w_count   = (in_count == '0 || in_count > CNT_W'(RATIO)) ? CNT_W'(RATIO) : in_count;
    assign w_rem_one = (r_rem == CNT_W'(1));
    assign in_ready  = !reset && ((r_state == ST_EMPTY) || (w_rem_one && out_ready));
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = r_out_valid && out_ready;
    assign w_final   = w_out_hs && w_rem_one;
    assign w_advance = w_out_hs && !w_rem_one;

    // The word register is loaded one step ahead: from the incoming beat on a
    // load, otherwise from the held beat at the next index.
    assign w_mux_src = w_in_hs ? in_data : r_hold;
    assign w_mux_idx = w_in_hs ? '0 : r_idx + 1'b1;

    unpacker_word_mux #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_word_mux (
        .i_data (w_mux_src),
        .i_idx  (w_mux_idx),
        .o_word (w_word)
    );

    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_hold <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_hold_last <= 1'b0;
            r_idx       <= '0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else if (w_in_hs) begin
            r_state     <= ST_HOLD;
            r_hold_last <= in_last;
            r_idx       <= '0;
            r_rem       <= w_count;
            r_out_valid <= 1'b1;
            r_out_last  <= (w_count == CNT_W'(1)) && in_last;
            r_out_data  <= w_word;
        end else if (w_final) begin
            r_state     <= ST_EMPTY;
            r_idx       <= '0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_advance) begin
            r_idx       <= r_idx + 1'b1;
            r_rem       <= r_rem - 1'b1;
            r_out_last  <= (r_rem == CNT_W'(2)) && r_hold_last;
            r_out_data  <= w_word;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_stream_unpacker.sv
// Bench for stream_unpacker: three configurations (128/64, 256/64, 128/32 MSB
// first) driven side by side and scored against a word-list model.
module tb_stream_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [2:0]   iv, ilast, ordy, ir, ov, ol;
    logic [255:0] idata [3];
    logic [2:0]   icnt  [3];
    logic [63:0]  od0, od1;
    logic [31:0]  od2;

    int tests = 0;
    int fails = 0;

    logic [64:0] sb [3][256];
    int          wr [3];
    int          rd [3];
    logic        stall [3];
    logic [64:0] prev  [3];

    int ro_tbl [6] = '{1, 0, 0, 1, 1, 1};
    int wi_tbl [6] = '{0, 1, 1, 1, 2, 3};
    int ir_tbl [6] = '{0, 0, 0, 0, 0, 1};
    int ol_tbl [6] = '{0, 0, 0, 0, 0, 1};

    stream_unpacker #(.IN_WIDTH(128), .OUT_WIDTH(64), .MSB_FIRST(0)) u_a (
        .clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(idata[0][127:0]), .in_count(icnt[0][1:0]), .in_last(ilast[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0), .out_last(ol[0]));

    stream_unpacker #(.IN_WIDTH(256), .OUT_WIDTH(64), .MSB_FIRST(0)) u_b (
        .clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(idata[1]), .in_count(icnt[1]), .in_last(ilast[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1), .out_last(ol[1]));

    stream_unpacker #(.IN_WIDTH(128), .OUT_WIDTH(32), .MSB_FIRST(1)) u_c (
        .clk(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(idata[2][127:0]), .in_count(icnt[2]), .in_last(ilast[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2), .out_last(ol[2]));

    function automatic int ratio_of(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic int width_of(input int k);
        return (k == 2) ? 32 : 64;
    endfunction

    function automatic logic [63:0] out_of(input int k);
        if (k == 0) return od0;
        if (k == 1) return od1;
        return {32'b0, od2};
    endfunction

    function automatic int eff_cnt(input int k);
        int c;
        c = (k == 0) ? int'(icnt[0][1:0]) : int'(icnt[k]);
        return (c == 0 || c > ratio_of(k)) ? ratio_of(k) : c;
    endfunction

    // Word i of a beat in emission order.
    function automatic logic [63:0] model_word(input int k, input logic [255:0] d, input int i);
        int pos;
        logic [255:0] s;
        pos = (k == 2) ? (ratio_of(k) - 1 - i) : i;
        s = d >> (pos * width_of(k));
        if (width_of(k) == 32) return {32'b0, s[31:0]};
        return s[63:0];
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                rd[k] = wr[k];
                stall[k] = 1'b0;
            end else begin
                if (stall[k])
                    chk($sformatf("hold_stable%0d", k), {ov[k], ol[k], out_of(k)}, {1'b1, prev[k]});
                if (ov[k] && ordy[k]) begin
                    chk($sformatf("word_expected%0d", k), 66'(rd[k] != wr[k]), 66'd1);
                    if (rd[k] != wr[k]) begin
                        chk($sformatf("word%0d", k), {ol[k], out_of(k)}, sb[k][rd[k] % 256]);
                        rd[k]++;
                    end
                end
                if (iv[k] && ir[k]) begin
                    for (int i = 0; i < eff_cnt(k); i++) begin
                        sb[k][wr[k] % 256] = {(i == eff_cnt(k) - 1) && ilast[k], model_word(k, idata[k], i)};
                        wr[k]++;
                    end
                end
                stall[k] = ov[k] && !ordy[k];
                prev[k]  = {ol[k], out_of(k)};
            end
        end
    endtask

    initial begin
        logic [63:0] w [4];
        int beat;
        logic hs;

        rst   = 1'b1;
        iv    = '0;
        ilast = '0;
        ordy  = 3'b111;
        for (int k = 0; k < 3; k++) begin
            idata[k] = '0;
            icnt[k]  = '0;
            wr[k] = 0;
            rd[k] = 0;
            stall[k] = 1'b0;
            prev[k]  = '0;
        end
        tick();
        tick();

        // reset state
        sample();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_in_ready%0d", k), 66'(ir[k]), 66'd0);
            chk($sformatf("rst_out_valid%0d", k), 66'(ov[k]), 66'd0);
            chk($sformatf("rst_out_last%0d", k), 66'(ol[k]), 66'd0);
            chk($sformatf("rst_out_data%0d", k), 66'(out_of(k)), 66'd0);
        end
        tick();
        rst = 1'b0;

        // 128/64 full beat, first word one cycle after handshake
        idata[0] = {128'h0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
        icnt[0] = 3'd0;
        iv[0] = 1'b1;
        sample();
        chk("a_ready_after_reset", 66'(ir[0]), 66'd1);
        chk("a_no_valid_before", 66'(ov[0]), 66'd0);
        tick();
        iv[0] = 1'b0;
        sample();
        chk("a_first_valid", 66'(ov[0]), 66'd1);
        chk("a_first_word", {ol[0], od0}, {1'b0, 64'h5555_5555_5555_5555});
        tick();
        sample();
        chk("a_second_word", {ov[0], ol[0], od0}, {2'b10, 64'hAAAA_AAAA_AAAA_AAAA});
        tick();
        sample();
        chk("a_idle_after", 66'(ov[0]), 66'd0);
        tick();

        // 256/64 partial beat: count=3 with last
        for (int i = 0; i < 4; i++) w[i] = 64'hB0B0_0000_0000_0000 | 64'(i);
        idata[1] = {w[3], w[2], w[1], w[0]};
        icnt[1] = 3'd3;
        ilast[1] = 1'b1;
        iv[1] = 1'b1;
        sample();
        chk("b_ready", 66'(ir[1]), 66'd1);
        tick();
        iv[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk($sformatf("b_partial_w%0d", i), {ov[1], ol[1], od1}, {1'b1, i == 2, w[i]});
            tick();
        end
        sample();
        chk("b_w3_never", 66'(ov[1]), 66'd0);
        tick();

        // 128/32 MSB first
        idata[2] = {128'h0, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        icnt[2] = 3'd0;
        ilast[2] = 1'b0;
        iv[2] = 1'b1;
        sample();
        tick();
        iv[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk($sformatf("c_msb_w%0d", i), {ov[2], ol[2], od2}, {2'b10, 32'h1111_1111 * (4 - i)});
            tick();
        end
        sample();
        chk("c_idle_after", 66'(ov[2]), 66'd0);
        tick();

        // 256/64 stalls: out_ready 1,0,0,1 holds the word and blocks input
        for (int i = 0; i < 4; i++) w[i] = 64'hF00D_0000_0000_0000 | 64'(i);
        idata[1] = {w[3], w[2], w[1], w[0]};
        icnt[1] = 3'd4;
        ilast[1] = 1'b1;
        iv[1] = 1'b1;
        sample();
        tick();
        iv[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            ordy[1] = ro_tbl[c][0];
            sample();
            chk($sformatf("stall_data%0d", c), {ov[1], od1}, {1'b1, w[wi_tbl[c]]});
            chk($sformatf("stall_last%0d", c), 66'(ol[1]), 66'(ol_tbl[c]));
            chk($sformatf("stall_in_ready%0d", c), 66'(ir[1]), 66'(ir_tbl[c]));
            tick();
        end
        ordy[1] = 1'b1;
        sample();
        chk("stall_idle_after", 66'(ov[1]), 66'd0);
        tick();

        // four back-to-back beats on 128/64, no bubbles
        beat = 0;
        icnt[0] = 3'd0;
        ilast[0] = 1'b0;
        idata[0] = {128'h0, 64'hC0C0_C0C0_C0C0_C001, 64'hC0C0_C0C0_C0C0_C000};
        iv[0] = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            sample();
            if (cyc >= 1 && cyc <= 8)
                chk($sformatf("b2b_word%0d", cyc - 1), {ov[0], od0}, {1'b1, 64'hC0C0_C0C0_C0C0_C000 | 64'(cyc - 1)});
            if (cyc == 0 || (cyc >= 2 && cyc <= 8 && cyc % 2 == 0))
                chk($sformatf("b2b_in_ready%0d", cyc), 66'(ir[0]), 66'd1);
            if (cyc == 9)
                chk("b2b_idle_after", 66'(ov[0]), 66'd0);
            hs = iv[0] && ir[0];
            tick();
            if (hs) begin
                beat++;
                if (beat == 4) iv[0] = 1'b0;
                else idata[0] = {128'h0, 64'hC0C0_C0C0_C0C0_C001 | 64'(2 * beat), 64'hC0C0_C0C0_C0C0_C000 | 64'(2 * beat)};
            end
        end

        // reset after the first of two words
        idata[0] = {128'h0, 64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
        iv[0] = 1'b1;
        sample();
        tick();
        iv[0] = 1'b0;
        sample();
        chk("rst_mid_first", {ov[0], od0}, {1'b1, 64'hD0D0_D0D0_D0D0_D0D0});
        tick();
        rst = 1'b1;
        sample();
        chk("rst_mid_in_ready", 66'(ir[0]), 66'd0);
        tick();
        rst = 1'b0;
        idata[0] = {128'h0, 64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};
        iv[0] = 1'b1;
        sample();
        chk("rst_mid_valid_cleared", 66'(ov[0]), 66'd0);
        chk("rst_mid_accept_new", 66'(ir[0]), 66'd1);
        tick();
        iv[0] = 1'b0;
        sample();
        chk("rst_mid_new_w0", {ov[0], od0}, {1'b1, 64'hE0E0_E0E0_E0E0_E0E0});
        tick();
        sample();
        chk("rst_mid_new_w1", {ov[0], od0}, {1'b1, 64'hE1E1_E1E1_E1E1_E1E1});
        tick();

        // randomized traffic on all three configurations
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 3; k++) begin
                iv[k]    = ($urandom_range(0, 9) < 7);
                ordy[k]  = ($urandom_range(0, 3) != 0);
                ilast[k] = $urandom_range(0, 1);
                icnt[k]  = 3'($urandom_range(0, (k == 0) ? 3 : 7));
                for (int j = 0; j < 8; j++) idata[k][j*32 +: 32] = $urandom;
            end
            sample();
            tick();
        end
        rst  = 1'b0;
        iv   = '0;
        ordy = 3'b111;
        repeat (8) begin
            sample();
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drain_empty%0d", k), 66'(wr[k] - rd[k]), 66'd0);
            chk($sformatf("drain_idle%0d", k), 66'(ov[k]), 66'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
